chunked_seq_adder: RTL

- Multi-cycle parametrised adder/subtractor that generalises the team's 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, carrying between cycles in a carry register, so wide adds close timing with a short carry chain.
- Adds subtract mode, signed-overflow detection and a start/done handshake.
- Sits in the Adders library as the datapath building block for wide accumulators and ALUs.

---
 rtl/chunked_seq_adder.sv | 71 +++++++
 1 files changed

// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: multi-cycle WIDTH-bit add/sub, CHUNK bits per clock with registered inter-chunk carry
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] opa, opb, acc, acc_n;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca, cb, s;
  logic             carry, c, c_msb, last;
  always_comb begin
    ca      = opa[idx*CHUNK +: CHUNK];
    cb      = opb[idx*CHUNK +: CHUNK];
    {c, s}  = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    // s = a ^ b ^ carry_in at every bit, so the carry into the MSB falls out of the MSB's sum bit
    c_msb   = ca[CHUNK-1] ^ cb[CHUNK-1] ^ s[CHUNK-1];
    last    = idx == IW'(N - 1);
    acc_n   = acc;
    acc_n[idx*CHUNK +: CHUNK] = s;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= cin ^ sub;
        idx   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_n;
        carry <= c;
        idx   <= last ? '0 : idx + IW'(1);
        if (last) begin
          sum  <= acc_n;
          cout <= c;
          ovf  <= c_msb ^ c;
        end
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule
